booth_csa_iter_mult: RTL and testbench

- Iterative radix-4 Booth multiplier front end. Folds one Booth partial product per cycle into a carry-save (sum, carry) accumulator.
- Outputs a redundant 2*WIDTH-bit pair. The team's 64-bit parallel-prefix final adder consumes this pair with Cin=0 and resolves it to the product.
- Sits directly upstream of that adder. It is a small-area, sequential alternative to the full Wallace tree.

---
 rtl/booth_pkg.sv | 35 +++
 rtl/booth_pp_gen.sv | 31 +++
 rtl/booth_csa_iter_mult.sv | 134 +++++++++++++
 tb/tb_booth_csa_iter_mult.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth / carry-save multiplier.
package booth_pkg;

    typedef struct packed {
        logic neg;
        logic two;
        logic one;
    } booth_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One digit per bit pair of the (WIDTH+2)-bit extended multiplier.
    function automatic int booth_ndig(input int width);
        return width / 2 + 1;
    endfunction

    // Window is {b[2k+1], b[2k], b[2k-1]}; all-ones maps to a plain zero digit.
    function automatic booth_digit_t booth_encode(input logic [2:0] win);
        booth_digit_t d;
        d = '0;
        unique case (win)
            3'b001, 3'b010: d = '{neg: 1'b0, two: 1'b0, one: 1'b1};
            3'b011:         d = '{neg: 1'b0, two: 1'b1, one: 1'b0};
            3'b100:         d = '{neg: 1'b1, two: 1'b1, one: 1'b0};
            3'b101, 3'b110: d = '{neg: 1'b1, two: 1'b0, one: 1'b1};
            default:        d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational Booth partial-product generator: pp = (digit * a_ext) << 2k,
// full-width two's complement with explicit invert-plus-one negation.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int KW    = 5
) (
    input  logic [2:0]         win,
    input  logic [2*WIDTH-1:0] a_ext,
    input  logic [KW-1:0]      k,
    output logic [2*WIDTH-1:0] pp
);

    booth_digit_t       dig;
    logic [2*WIDTH-1:0] mag;
    logic [2*WIDTH-1:0] val;

    always_comb begin
        dig = booth_encode(win);
        mag = '0;
        if (dig.one) begin
            mag = a_ext;
        end else if (dig.two) begin
            mag = a_ext << 1;
        end
        val = dig.neg ? (~mag + 1'b1) : mag;
        pp  = val << {k, 1'b0};
    end

endmodule

// File: rtl/booth_csa_iter_mult.sv
// Iterative radix-4 Booth multiplier front end: one partial product per cycle
// folded into a carry-save pair; the downstream adder resolves sum + carry.
//
// state | meaning
// IDLE  | ready for operands; outputs hold the previous result
// RUN   | counter 0..NDIG-1 folds pp_counter; counter==NDIG loads the output pair
// DONE  | out_valid high, result held until out_ready
module booth_csa_iter_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_sum,
    output logic [2*WIDTH-1:0] out_carry
);

    localparam int NDIG = booth_ndig(WIDTH);
    localparam int PW   = 2 * WIDTH;
    localparam int CW   = $clog2(NDIG + 1);

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic             last_step;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sgn_q;

    logic [PW-1:0]    a_ext;
    logic [WIDTH+2:0] b_pad;
    logic [2:0]       win;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    s, c, s_nxt, c_nxt;

    assign last_step = (cnt == CW'(NDIG));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Extension works from the latched raw operands so the sign mode stays live.
    assign a_ext = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
    assign b_pad = {{2{sgn_q & b_q[WIDTH-1]}}, b_q, 1'b0};
    assign win   = 3'(b_pad >> {cnt, 1'b0});

    booth_pp_gen #(
        .WIDTH (WIDTH),
        .KW    (CW)
    ) u_pp_gen (
        .win   (win),
        .a_ext (a_ext),
        .k     (cnt),
        .pp    (pp)
    );

    assign s_nxt = s ^ c ^ pp;
    assign c_nxt = ((s & c) | (s & pp) | (c & pp)) << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            s         <= '0;
            c         <= '0;
            out_sum   <= '0;
            out_carry <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        sgn_q <= in_signed;
                        s     <= '0;
                        c     <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (last_step) begin
                        out_sum   <= s;
                        out_carry <= c;
                    end else begin
                        s   <= s_nxt;
                        c   <= c_nxt;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_csa_iter_mult.sv
// Self-checking bench for booth_csa_iter_mult: directed corner products,
// backpressure, mid-run reset and randomized back-to-back traffic.
module tb_booth_csa_iter_mult;

    localparam int W   = 32;
    localparam int LAT = W / 2 + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_signed = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2*W-1:0] out_sum;
    logic [2*W-1:0] out_carry;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    booth_csa_iter_mult #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry)
    );

    function automatic logic [63:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sgn);
        longint sa, sb;
        logic [63:0] ua, ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input int stall, output logic [63:0] res, output int lat,
                         output bit tmo, output int rdy_hits);
        int n;
        tmo = 1'b0; rdy_hits = 0; lat = 0; res = '0; n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            tmo = 1'b1;
            return;
        end
        in_a = a; in_b = b; in_signed = sgn; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_signed = 1'($urandom);
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_hits++;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            tmo = 1'b1;
            return;
        end
        res = out_sum + out_carry;
        repeat (stall) begin
            @(posedge clk); #1;
            if (in_ready) rdy_hits++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks += 4;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum got %h want 0", out_sum); end
        if (out_carry !== '0) begin n_fail++; $display("FAIL reset_out_carry got %h want 0", out_carry); end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [6] = '{32'd3, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
        logic [W-1:0] tb [6] = '{32'd5, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
        logic         ts [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [63:0]  te [6] = '{64'h000000000000000F, 64'h1, 64'h4000000000000000,
                                 64'hFFFFFFFE00000001, 64'h1, 64'h0};
        logic [63:0] res;
        int lat, hits;
        bit tmo;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], ts[i], 0, res, lat, tmo, hits);
            n_checks += 3;
            if (tmo) begin n_fail++; $display("FAIL directed_timeout case %0d", i); end
            if (res !== te[i]) begin n_fail++; $display("FAIL directed_product case %0d got %h want %h", i, res, te[i]); end
            if (lat != LAT) begin n_fail++; $display("FAIL directed_latency case %0d got %0d want %0d", i, lat, LAT); end
        end
    endtask

    task automatic test_backpressure();
        logic [2*W-1:0] s0, c0;
        logic [63:0] expv, sum0;
        int n;
        expv = ref_mult(32'hDEADBEEF, 32'h0BADF00D, 1'b1);
        n = 0;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        in_a = 32'hDEADBEEF; in_b = 32'h0BADF00D; in_signed = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (!out_valid) begin n_fail++; $display("FAIL bp_timeout got no out_valid"); end
        s0 = out_sum; c0 = out_carry;
        sum0 = s0 + c0;
        n_checks++;
        if (sum0 !== expv) begin n_fail++; $display("FAIL bp_product got %h want %h", sum0, expv); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i % 2); in_a = $urandom; in_b = $urandom; in_signed = 1'($urandom);
            @(posedge clk); #1;
            n_checks += 4;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc %0d got %b want 1", i, out_valid); end
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); end
            if (out_sum !== s0) begin n_fail++; $display("FAIL bp_sum_stable cyc %0d got %h want %h", i, out_sum, s0); end
            if (out_carry !== c0) begin n_fail++; $display("FAIL bp_carry_stable cyc %0d got %h want %h", i, out_carry, c0); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        if (out_sum !== s0) begin n_fail++; $display("FAIL bp_hold_after_idle got %h want %h", out_sum, s0); end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] res;
        int lat, hits, n;
        bit tmo;
        n = 0;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        in_a = 32'h7FFFFFFF; in_b = 32'h7FFFFFFF; in_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks += 4;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        if (out_sum !== '0) begin n_fail++; $display("FAIL midrst_out_sum got %h want 0", out_sum); end
        if (out_carry !== '0) begin n_fail++; $display("FAIL midrst_out_carry got %h want 0", out_carry); end
        do_op(32'd7, 32'hFFFFFFF7, 1'b1, 2, res, lat, tmo, hits);
        n_checks += 3;
        if (tmo) begin n_fail++; $display("FAIL midrst_timeout"); end
        if (res !== 64'hFFFFFFFFFFFFFFC1) begin n_fail++; $display("FAIL midrst_product got %h want %h", res, 64'hFFFFFFFFFFFFFFC1); end
        if (lat != LAT) begin n_fail++; $display("FAIL midrst_latency got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res, expv;
        logic [W-1:0] a, b;
        logic sgn;
        int lat, hits, stall, bad_prod, bad_lat, bad_rdy, tmos;
        bit tmo;
        bad_prod = 0; bad_lat = 0; bad_rdy = 0; tmos = 0;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom; b = $urandom; sgn = 1'($urandom);
            case ($urandom_range(0, 7))
                0: a = 32'h80000000;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h0;
                default: ;
            endcase
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            expv = ref_mult(a, b, sgn);
            do_op(a, b, sgn, stall, res, lat, tmo, hits);
            if (tmo) begin
                tmos++;
            end else begin
                if (res !== expv) begin
                    bad_prod++;
                    if (bad_prod < 5) $display("FAIL b2b_product a=%h b=%h s=%b got %h want %h", a, b, sgn, res, expv);
                end
                if (lat != LAT) bad_lat++;
                bad_rdy += hits;
            end
        end
        n_checks += 4;
        if (tmos != 0) begin n_fail++; $display("FAIL b2b_timeouts got %0d want 0", tmos); end
        if (bad_prod != 0) begin n_fail++; $display("FAIL b2b_products wrong %0d want 0", bad_prod); end
        if (bad_lat != 0) begin n_fail++; $display("FAIL b2b_latency wrong %0d want 0", bad_lat); end
        if (bad_rdy != 0) begin n_fail++; $display("FAIL b2b_in_ready_busy got %0d want 0", bad_rdy); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
